// File: rtl/alu16_arbiter.sv
// Two-requester round-robin front end for the shared 16-bit ALU: decodes function codes,
// sequences IDLE/EXEC/RESP and returns a tagged, held response with signed overflow.
module alu16_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_fn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_fn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int unsigned MSB = WIDTH - 1;

  state_t           state, state_nx;
  logic             last;
  logic [2:0]       fn_q;
  logic             id_q;
  logic             gnt0, gnt1;
  logic             accept;
  logic             sel_id;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_fn;
  logic             fn_illegal;
  logic             ovf;

  // {ainvert, bnegate, cin, op}; illegal codes park the ALU on plain AND.
  function automatic logic [5:0] decode(input logic [2:0] fn);
    case (fn)
      3'b000:  decode = 6'b000_000;
      3'b001:  decode = 6'b000_001;
      3'b010:  decode = 6'b000_010;
      3'b011:  decode = 6'b011_010;
      3'b100:  decode = 6'b110_000;
      3'b101:  decode = 6'b110_001;
      default: decode = 6'b000_000;
    endcase
  endfunction

  // On a tie the requester not granted last time wins; last resets to 1 so req0 wins first.
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || last);
    gnt1       = req1_valid && (!req0_valid || !last);
    req0_ready = (state == IDLE) && !reset && gnt0;
    req1_ready = (state == IDLE) && !reset && gnt1;
    accept     = req0_ready || req1_ready;
    sel_id     = req1_ready;
    sel_a      = sel_id ? req1_a  : req0_a;
    sel_b      = sel_id ? req1_b  : req0_b;
    sel_fn     = sel_id ? req1_fn : req0_fn;
  end

  always_comb begin
    fn_illegal = fn_q[2] && fn_q[1];
    ovf        = 1'b0;
    if (fn_q == 3'b010)
      ovf = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
    else if (fn_q == 3'b011)
      ovf = (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // alu_a/alu_b double as the latched operands for the overflow calculation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last        <= 1'b1;
      fn_q        <= '0;
      id_q        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cin     <= 1'b0;
      alu_ainvert <= 1'b0;
      alu_bnegate <= 1'b0;
      alu_op      <= '0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_cout    <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_err     <= 1'b0;
      ops_done    <= '0;
    end else begin
      if (accept) begin
        alu_a <= sel_a;
        alu_b <= sel_b;
        {alu_ainvert, alu_bnegate, alu_cin, alu_op} <= decode(sel_fn);
        fn_q  <= sel_fn;
        id_q  <= sel_id;
        last  <= sel_id;
      end
      if (state == EXEC) begin
        rsp_id <= id_q;
        if (fn_illegal) begin
          rsp_result <= '0;
          rsp_cout   <= 1'b0;
          rsp_zero   <= 1'b0;
          rsp_ovf    <= 1'b0;
          rsp_err    <= 1'b1;
        end else begin
          rsp_result <= alu_result;
          rsp_cout   <= alu_cout;
          rsp_zero   <= alu_zero;
          rsp_ovf    <= ovf;
          rsp_err    <= 1'b0;
        end
      end
      if ((state == RESP) && rsp_ready)
        ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu16_arbiter.sv
// Bench for alu16_arbiter: behavioural ALU on the alu_* side, transaction-level reference
// model (grant order, latency, arithmetic) checked every cycle on the falling edge.
module tb_alu16_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_fn, req1_fn;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_cout, rsp_zero, rsp_ovf, rsp_err;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_cin, alu_ainvert, alu_bnegate, alu_cout, alu_zero;
  logic [2:0]   alu_op;
  logic         busy;
  logic [15:0]  ops_done;

  always #5 clk = ~clk;

  alu16_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ainvert(alu_ainvert),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .busy(busy), .ops_done(ops_done)
  );

  // Stand-in for alu_16bit: invert/negate muxes, adder carry always reported.
  logic [W-1:0] aa, bb;
  logic [W:0]   sum;
  always_comb begin
    aa  = alu_ainvert ? ~alu_a : alu_a;
    bb  = alu_bnegate ? ~alu_b : alu_b;
    sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, alu_cin};
    case (alu_op)
      3'b000:  alu_result = aa & bb;
      3'b001:  alu_result = aa | bb;
      3'b010:  alu_result = sum[W-1:0];
      default: alu_result = '0;
    endcase
    alu_cout = sum[W];
    alu_zero = (alu_result == '0);
  end

  typedef struct { logic [W-1:0] a, b; logic [2:0] fn; } op_t;
  typedef struct {
    logic id; logic [W-1:0] a, b; logic [2:0] fn;
    logic [W-1:0] result; logic cout, zero, ovf, err; int due;
  } exp_t;

  op_t  q0[$], q1[$];
  exp_t sb[$];
  op_t  cur0, cur1;
  int   checks = 0, failures = 0;
  int   cyc = 0, m_count = 0, rr_mode = 0;
  bit   m_last = 1'b1, m_busy = 1'b0, granted0_now = 1'b0, dense = 1'b1, drop_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl(input logic [2:0] fn);
    case (fn)
      3'd0: return 6'b000000;
      3'd1: return 6'b000001;
      3'd2: return 6'b000010;
      3'd3: return 6'b011010;
      3'd4: return 6'b110000;
      3'd5: return 6'b110001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic exp_t refmodel(input bit id, input op_t o, input int due);
    exp_t e;
    int unsigned ua, ub;
    int sa, sbv, s;
    ua = o.a; ub = o.b; sa = $signed(o.a); sbv = $signed(o.b);
    e.id = id; e.a = o.a; e.b = o.b; e.fn = o.fn; e.due = due;
    e.ovf = 1'b0; e.err = 1'b0;
    case (o.fn)
      3'd0: begin e.result = o.a & o.b; e.cout = (ua + ub) > 65535; end
      3'd1: begin e.result = o.a | o.b; e.cout = (ua + ub) > 65535; end
      3'd2: begin
        e.result = 16'(ua + ub); e.cout = (ua + ub) > 65535;
        s = sa + sbv; e.ovf = (s > 32767) || (s < -32768);
      end
      3'd3: begin
        e.result = 16'(ua - ub); e.cout = (ua >= ub);
        s = sa - sbv; e.ovf = (s > 32767) || (s < -32768);
      end
      3'd4: begin e.result = ~(o.a | o.b); e.cout = (ua + ub) <= 65534; end
      3'd5: begin e.result = ~(o.a & o.b); e.cout = (ua + ub) <= 65534; end
      default: begin e.result = '0; e.cout = 1'b0; e.err = 1'b1; end
    endcase
    e.zero = !e.err && (e.result == '0);
    return e;
  endfunction

  task automatic model_clear();
    sb.delete(); m_last = 1'b1; m_busy = 1'b0; m_count = 0;
  endtask

  task automatic monitor(output bit acc0, output bit acc1);
    bit e0, e1, was_busy;
    exp_t e;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    granted0_now = 1'b0;
    if (reset) begin model_clear(); return; end
    cyc++;
    was_busy = m_busy;
    e0 = !was_busy && req0_valid && (!req1_valid || m_last);
    e1 = !was_busy && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("busy", busy, was_busy);
    chk("ops_done", ops_done, m_count[15:0]);
    if (was_busy) begin
      e = sb[0];
      if (cyc == e.due - 1 && !e.err) begin
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_ctl", {alu_ainvert, alu_bnegate, alu_cin, alu_op}, ctl(e.fn));
      end
      chk("rsp_valid", rsp_valid, cyc >= e.due);
      if (cyc >= e.due) begin
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_result", rsp_result, e.result);
        chk("rsp_flags", {rsp_cout, rsp_zero, rsp_ovf, rsp_err}, {e.cout, e.zero, e.ovf, e.err});
        if (rsp_ready) begin
          void'(sb.pop_front());
          m_count++;
          m_busy = 1'b0;
        end
      end
    end else begin
      chk("rsp_valid", rsp_valid, 1'b0);
    end
    if (e0 || e1) begin
      sb.push_back(refmodel(e1, e1 ? cur1 : cur0, cyc + 2));
      m_last = e1;
      m_busy = 1'b1;
      granted0_now = e0;
    end
  endtask

  task automatic drive(input bit acc0, input bit acc1);
    bit d0, d1;
    d0 = 1'b0; d1 = 1'b0;
    if (acc0) req0_valid = 1'b0;
    else if (req0_valid && drop_en && $urandom_range(0, 15) == 0) begin
      req0_valid = 1'b0; q0.push_front(cur0); d0 = 1'b1;
    end
    if (acc1) req1_valid = 1'b0;
    else if (req1_valid && drop_en && $urandom_range(0, 15) == 0) begin
      req1_valid = 1'b0; q1.push_front(cur1); d1 = 1'b1;
    end
    if (!req0_valid) begin
      req0_a = W'($urandom); req0_b = W'($urandom); req0_fn = 3'($urandom);
      if (!d0 && q0.size() > 0 && (dense || $urandom_range(0, 2) == 0)) begin
        cur0 = q0.pop_front();
        req0_valid = 1'b1; req0_a = cur0.a; req0_b = cur0.b; req0_fn = cur0.fn;
      end
    end
    if (!req1_valid) begin
      req1_a = W'($urandom); req1_b = W'($urandom); req1_fn = 3'($urandom);
      if (!d1 && q1.size() > 0 && (dense || $urandom_range(0, 2) == 0)) begin
        cur1 = q1.pop_front();
        req1_valid = 1'b1; req1_a = cur1.a; req1_b = cur1.b; req1_fn = cur1.fn;
      end
    end
    case (rr_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  endtask

  task automatic step();
    bit a0, a1;
    @(negedge clk);
    monitor(a0, a1);
    @(posedge clk);
    #1;
    drive(a0, a1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_flags"}, {rsp_cout, rsp_zero, rsp_ovf, rsp_err}, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_ctl"}, {alu_ainvert, alu_bnegate, alu_cin, alu_op}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ops_done"}, ops_done, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_zero("rst");
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] corner [6];
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h8001};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  initial begin
    bit found;
    int guard;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_fn = '0;
    req1_a = '0; req1_b = '0; req1_fn = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("por");
    reset = 1'b0;

    // Directed vectors from the test plan.
    q0.push_back('{16'h000F, 16'h000E, 3'd2});
    q1.push_back('{16'd1001, 16'd12341, 3'd3});
    q1.push_back('{16'h0F0F, 16'h0F0F, 3'd3});
    q0.push_back('{16'h0002, 16'h0001, 3'd4});
    q0.push_back('{16'h7FFF, 16'h0001, 3'd2});
    q1.push_back('{16'h1234, 16'h5678, 3'd7});
    q1.push_back('{16'hF0F0, 16'h0FF0, 3'd5});
    run(40);

    // Both requesters continuously valid from reset: grants 0,1,0,1.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{rnd_operand(), rnd_operand(), 3'd2});
      q1.push_back('{rnd_operand(), rnd_operand(), 3'd0});
    end
    run(16);
    chk("ops_after_arb", ops_done, 16'd4);

    // Response backpressure with the other requester waiting.
    rr_mode = 2;
    q0.push_back('{16'h8000, 16'h0001, 3'd3});
    q1.push_back('{16'h0003, 16'h0005, 3'd1});
    run(9);
    rr_mode = 0;
    run(10);

    // Reset during EXEC of a req0 operation.
    q0.push_back('{16'h1111, 16'h2222, 3'd2});
    q0.push_back('{16'h3333, 16'h0003, 3'd0});
    q0.push_back('{16'h4444, 16'h0004, 3'd1});
    q1.push_back('{16'h5555, 16'h0005, 3'd3});
    q1.push_back('{16'h6666, 16'h0006, 3'd4});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (granted0_now) begin
        #2 reset = 1'b1;
        #1 chk_zero("midop");
        model_clear();
        found = 1'b1;
      end
    end
    chk("midop_grant_seen", found, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    run(25);

    // Randomized traffic with gaps, drops and random backpressure.
    dense = 1'b0; drop_en = 1'b1; rr_mode = 1;
    for (int i = 0; i < 150; i++) begin
      q0.push_back('{rnd_operand(), rnd_operand(), 3'($urandom)});
      q1.push_back('{rnd_operand(), rnd_operand(), 3'($urandom)});
    end
    guard = 0;
    while (guard < 5000 &&
           (q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || req0_valid || req1_valid)) begin
      step();
      guard++;
    end
    chk("drain_pending", q0.size() + q1.size() + sb.size() + 32'(req0_valid) + 32'(req1_valid), 0);
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu16_arbiter.md
# alu16_arbiter

Sequencing and arbitration controller for the shared 16-bit ALU (`alu_16bit`). It accepts operation requests from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It decodes a 3-bit function code into the ALU control lines (`ainvert`, `bnegate`, `cin`, `op[2:0]`), captures the ALU outputs, computes signed overflow, and returns a tagged response. It sits between the datapath clients and the single ALU instance.

## Interface

Parameters:
- `WIDTH`, default 16, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_fn`, `req1_fn`  in  3  function code
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  1  requester index (0/1)
- `rsp_result`  out  WIDTH  result
- `rsp_cout`, `rsp_zero`, `rsp_ovf`, `rsp_err`  out  1  carry, zero, signed overflow, illegal function
- `alu_a`, `alu_b`  out  WIDTH  ALU operands
- `alu_cin`, `alu_ainvert`, `alu_bnegate`  out  1  ALU controls
- `alu_op`  out  3  ALU op select
- `alu_result`  in  WIDTH; `alu_cout`, `alu_zero`  in  1  ALU outputs (combinational)
- `busy`  out  1  state != IDLE
- `ops_done`  out  16  completed-response counter

## Operation

- **Function decode** to {ainvert, bnegate, cin, op}:
  - 000 AND → 0,0,0,000
  - 001 OR → 0,0,0,001
  - 010 ADD → 0,0,0,010
  - 011 SUB → 0,1,1,010
  - 100 NOR → 1,1,0,000
  - 101 NAND → 1,1,0,001
  - 110, 111 illegal
- **FSM states:** IDLE → EXEC → RESP → IDLE.
  - **IDLE:** if any `reqN_valid`, grant one requester (rules below). `reqN_ready` is 1 only for the granted requester, combinationally, only in IDLE. On the handshake, latch a, b, fn and the id, drive the decoded ALU controls from registers, and go to EXEC.
  - **EXEC:** the ALU inputs are stable from registers. At the end of the cycle, capture `alu_result`, `alu_cout` and `alu_zero`. Overflow is computed as follows:
    - ADD: (a[15]==b[15]) && (r[15]!=a[15])
    - SUB: (a[15]!=b[15]) && (r[15]!=a[15])
    - all other functions: 0
    - Go to RESP.
  - **Illegal fn:** EXEC is still taken, but captured values are forced to result=0, cout=0, zero=0, ovf=0, err=1.
  - **RESP:** `rsp_valid`=1 and all `rsp_*` are held stable until `rsp_valid && rsp_ready`. On that handshake, increment `ops_done` (wraps 0xFFFF→0) and go to IDLE.
- **Round-robin arbitration:**
  - The `last` pointer updates on every grant.
  - If both requesters are valid, grant the one not equal to `last`.
  - If one is valid, grant it.
  - After reset `last`=1, so req0 wins the first tie.
- `alu_*` outputs hold their last values outside EXEC. They are zero after reset.

## Timing

- **Reset values:** state IDLE, all outputs 0 (`reqN_ready`, `rsp_*`, `alu_*`, `busy`, `ops_done`), `last`=1.
- **Latency:** request accepted at cycle T; `rsp_valid` rises at T+2. With `rsp_ready` held high, the next accept is possible at T+3, so maximum throughput is 1 op / 3 cycles.
- **Requester rules:** a requester must hold valid and data stable until ready. Dropping valid before grant is legal and causes no side effect.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely. No new request is accepted, and both readys stay 0.
- **Reset mid-operation:** asynchronous return to the reset state. Any in-flight request is discarded with no response, and `ops_done` is cleared.

## Test plan

- **ADD:** req0 fn=010, a=0x000F, b=0x000E → one response at T+2: id=0, result=0x001D, cout=0, zero=0, ovf=0, err=0. ALU controls were 0,0,0,010 during EXEC.
- **SUB:** req1 fn=011, a=1001, b=12341 → result=0xD3B4, cout=0, ovf=0. A second SUB with a=b=0x0F0F → result=0, zero=1, cout=1.
- **NOR, overflow and illegal:**
  - NOR a=2, b=1 → 0xFFFC.
  - ADD 0x7FFF+0x0001 → 0x8000, ovf=1.
  - fn=111 → result=0, err=1.
- **Arbitration:** req0 and req1 both valid continuously from reset → grant order 0,1,0,1. `rsp_id` alternates, and `ops_done`=4 after four handshakes.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, both readys 0, `busy`=1. Raising `rsp_ready` completes the handshake and returns to IDLE next cycle.
- **Reset mid-op:** assert `reset` during EXEC → all outputs 0 immediately. After release, a pending req1 is granted, and tie priority is back to req0.
